uart_tx_scheduler: RTL

Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters. Picks a requester, issues a one-cycle start strobe with the chosen byte, then tracks the transmitter's busy flag through the frame. Enforces an inter-frame gap counted in baud ticks from the baud clock generator's tx_clk output. Sits between the APB-side request sources and the UART TX datapath.

---
 rtl/uart_tx_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter; gnt/tx_start pulse one clock after req is sampled in IDLE.
// Requesters hold req until gnt; requests wait while a frame, busy timeout or inter-frame gap is in progress.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_TICKS    = 1,
  parameter int BUSY_TIMEOUT = 64,
  localparam int OWNER_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_tick,
  output logic [OWNER_W-1:0]        owner,
  output logic                      sched_busy,
  output logic                      err_timeout
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_TICKS) ? BUSY_TIMEOUT : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  logic [OWNER_W-1:0] last;
  logic [CNT_W-1:0]   cnt;

  logic [OWNER_W-1:0] pick;
  logic               pick_vld;
  logic [DATA_W-1:0]  pick_data;

  // First requesting index after the last grant, wrapping, so the one just served goes to the back.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_vld && req[OWNER_W'((int'(last) + i) % NUM_REQ)]) begin
        pick_vld = 1'b1;
        pick     = OWNER_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == OWNER_W'(i)) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= OWNER_W'(NUM_REQ - 1);
      cnt         <= '0;
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      owner       <= '0;
      err_timeout <= 1'b0;
    end else begin
      gnt         <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= START;
            tx_start <= 1'b1;
            gnt      <= NUM_REQ'(1) << pick;
            tx_data  <= pick_data;
            owner    <= pick;
            last     <= pick;
          end
        end
        START: begin
          state <= WAIT_BUSY;
          cnt   <= '0;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            // Byte counts as consumed: drop straight back to arbitration without a gap.
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            state <= (GAP_TICKS > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (tx_tick) begin
            if (cnt == CNT_W'(GAP_TICKS - 1)) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
